// File: rtl/pulse_generator.sv
// pulse_generator: emits bursts of qualified negative-edge pulses (LOW_CYC low, HIGH_CYC high)
// followed by a LOW_CYC tail, with registered pulse_o/busy/done outputs.
`default_nettype none
`timescale 1ns/1ps

module pulse_generator #(
  parameter int LOW_CYC  = 6,
  parameter int HIGH_CYC = 6,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic             abort,
  output logic             pulse_o,
  output logic             busy,
  output logic             done
);

  localparam int MAX_CYC = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYC - 1);
  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (num_pulses != '0) begin
            rem_d   = num_pulses;
            ph_d    = '0;
            state_d = S_LOW;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOW: begin
        if (ph_q == LOW_LAST) begin
          ph_d    = '0;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_HIGH: begin
        if (ph_q == HIGH_LAST) begin
          ph_d    = '0;
          state_d = (rem_q > CNT_W'(1)) ? S_LOW : S_TAIL;
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_TAIL: begin
        if (ph_q == LOW_LAST) begin
          ph_d    = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase

    // Abort wins over any phase expiry and never produces a done strobe.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ph_d    = '0;
      rem_d   = '0;
      done_d  = 1'b0;
    end

    // Outputs are registered images of the next state.
    pulse_d = (state_d == S_HIGH);
    busy_d  = (state_d != S_IDLE);
  end

  assign pulse_o = pulse_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: scoreboard bench for pulse_generator; expected {pulse_o,busy,done}
// per cycle is queued at stimulus time and popped one entry per clock.
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_generator;

  localparam int L = 6;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] num_pulses;
  logic       abort;
  logic       pulse_o;
  logic       busy;
  logic       done;

  pulse_generator #(.LOW_CYC(L), .HIGH_CYC(H), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_pulses (num_pulses),
    .abort      (abort),
    .pulse_o    (pulse_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [2:0] sb[$];
  string      tag = "init";
  int         n_checks = 0;
  int         n_pass = 0;

  // Software model of the receive-side detector.
  int det_cnt = 0;
  int low_cnt = 0;
  int high_cnt = 0;
  bit qual_low = 1'b0;

  task automatic check(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", t, act, exp, $time);
  endtask

  task automatic detect(input logic p);
    if (!p) begin
      if (high_cnt > 0) begin
        if (qual_low && high_cnt >= H) det_cnt++;
        high_cnt = 0;
        qual_low = 1'b0;
      end
      low_cnt++;
    end else begin
      if (low_cnt > 0) begin
        qual_low = (low_cnt >= L);
        low_cnt  = 0;
      end
      high_cnt++;
    end
  endtask

  task automatic tick();
    logic [2:0] e;
    @(posedge clk);
    #1;
    detect(pulse_o);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(tag, {pulse_o, busy, done}, e);
    end
  endtask

  task automatic push_n(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) sb.push_back(v);
  endtask

  task automatic push_burst(input int n);
    push_n(3'b010, L);
    for (int i = 0; i < n; i++) begin
      push_n(3'b110, H);
      push_n(3'b010, L);
    end
    push_n(3'b001, 1);
  endtask

  task automatic drain();
    while (sb.size() > 0) tick();
  endtask

  task automatic run_burst(input int n);
    start      = 1'b1;
    num_pulses = 8'(n);
    push_burst(n);
    push_n(3'b000, 2);
    tick();
    start = 1'b0;
    drain();
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    num_pulses = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {pulse_o, busy, done}, 3'b000);
    reset_n = 1'b1;
    tick();

    tag = "single"; det_cnt = 0;
    run_burst(1);
    check("single_det", det_cnt, 1);

    tag = "triple"; det_cnt = 0;
    run_burst(3);
    check("triple_det", det_cnt, 3);

    tag = "zero";
    start = 1'b1; num_pulses = 8'd0;
    push_n(3'b001, 1); push_n(3'b000, 3);
    tick();
    start = 1'b0;
    drain();

    tag = "abort_idle";
    start = 1'b1; abort = 1'b1; num_pulses = 8'd3;
    push_n(3'b000, 3);
    tick();
    start = 1'b0; abort = 1'b0;
    drain();

    // Restart mid-burst is ignored; restart during the done cycle is accepted.
    tag = "b2b"; det_cnt = 0;
    start = 1'b1; num_pulses = 8'd2;
    push_burst(2);
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; num_pulses = 8'd5;
    tick();
    start = 1'b0; num_pulses = 8'd0;
    drain();
    start = 1'b1; num_pulses = 8'd1;
    push_burst(1); push_n(3'b000, 2);
    tick();
    start = 1'b0;
    drain();
    check("b2b_det", det_cnt, 3);

    tag = "abort"; det_cnt = 0;
    start = 1'b1; num_pulses = 8'd4;
    push_n(3'b010, L); push_n(3'b110, H); push_n(3'b010, L); push_n(3'b110, 3);
    tick();
    start = 1'b0;
    drain();
    abort = 1'b1;
    push_n(3'b000, 4);
    tick();
    abort = 1'b0;
    drain();
    check("abort_det", det_cnt, 1);

    tag = "reset_mid"; det_cnt = 0;
    start = 1'b1; num_pulses = 8'd2;
    push_n(3'b010, L); push_n(3'b110, 3);
    tick();
    start = 1'b0;
    drain();
    reset_n = 1'b0;
    #1;
    check("rst_async", {pulse_o, busy, done}, 3'b000);
    @(posedge clk);
    #1;
    check("rst_hold", {pulse_o, busy, done}, 3'b000);
    reset_n = 1'b1;
    push_n(3'b000, 3);
    drain();
    run_burst(2);
    check("reset_det", det_cnt, 2);

    tag = "max"; det_cnt = 0;
    run_burst(255);
    check("max_det", det_cnt, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
